// File: rtl/captura_operandos.sv
// captura_operandos: operand-entry and result-capture controller for the
// calculator datapath. Two button presses load operands A and B from the
// switch bank into the external multiplier. One cycle later the product
// halves and the derived status flags are registered for the display stage.
module captura_operandos #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw,
  input  logic         btn_load,
  input  logic         btn_clr,
  input  logic [N-1:0] R,
  input  logic [N-1:0] Of,
  output logic [N-1:0] x,
  output logic [N-1:0] y,
  output logic [N-1:0] res_q,
  output logic [N-1:0] of_q,
  output logic         flag_ov,
  output logic         flag_z,
  output logic         valid,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    CALC   = 2'b10,
    SHOW   = 2'b11
  } state_t;

  state_t cur;

  logic ld_s1, ld_s2, ld_s3;
  logic clr_s1, clr_s2, clr_s3;
  logic ld_p, clr_p;

  // Two-flop synchronizers plus a third flop for rising-edge detection on both buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_s1  <= 1'b0;
      ld_s2  <= 1'b0;
      ld_s3  <= 1'b0;
      clr_s1 <= 1'b0;
      clr_s2 <= 1'b0;
      clr_s3 <= 1'b0;
    end else begin
      ld_s1  <= btn_load;
      ld_s2  <= ld_s1;
      ld_s3  <= ld_s2;
      clr_s1 <= btn_clr;
      clr_s2 <= clr_s1;
      clr_s3 <= clr_s2;
    end
  end

  assign ld_p  = ld_s2 & ~ld_s3;
  assign clr_p = clr_s2 & ~clr_s3;

  // Operand/result FSM: clear beats everything, including a pending load or result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= WAIT_A;
      x       <= '0;
      y       <= '0;
      res_q   <= '0;
      of_q    <= '0;
      flag_ov <= 1'b0;
      flag_z  <= 1'b0;
      valid   <= 1'b0;
    end else if (clr_p) begin
      cur     <= WAIT_A;
      x       <= '0;
      y       <= '0;
      res_q   <= '0;
      of_q    <= '0;
      flag_ov <= 1'b0;
      flag_z  <= 1'b0;
      valid   <= 1'b0;
    end else begin
      case (cur)
        WAIT_A: begin
          if (ld_p) begin
            x   <= sw;
            cur <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (ld_p) begin
            y   <= sw;
            cur <= CALC;
          end
        end
        CALC: begin
          res_q   <= R;
          of_q    <= Of;
          flag_ov <= |Of;
          flag_z  <= (R == '0) && (Of == '0);
          valid   <= 1'b1;
          cur     <= SHOW;
        end
        SHOW: begin
          if (ld_p) begin
            x     <= sw;
            valid <= 1'b0;
            cur   <= WAIT_B;
          end
        end
        default: cur <= WAIT_A;
      endcase
    end
  end

  assign state = cur;

endmodule

// File: doc/captura_operandos.md
# captura_operandos

Sequential operand-entry and result-capture controller for the calculator datapath. It captures the two operands from the switch bank on button presses and drives them into the combinational N-bit multiplier. After the multiplier settles it registers the low result half, the high overflow half and the derived status flags for the display stage. Only the multiplier consumes its `x`/`y` outputs; only the display/flag logic consumes its registered results.

## Interface
- `N`, default 4: operand width. Must match the multiplier's `N`.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sw`  in  N  operand value from the switch bank; sampled only on a load event.
- `btn_load`  in  1  raw load button, active-high, asynchronous to `clk`.
- `btn_clr`  in  1  raw clear button, active-high, asynchronous to `clk`.
- `R`  in  N  low half of the product, from the multiplier.
- `Of`  in  N  high half of the product, from the multiplier.
- `x`  out  N  registered operand A, to the multiplier.
- `y`  out  N  registered operand B, to the multiplier.
- `res_q`  out  N  registered low half of the product.
- `of_q`  out  N  registered high half of the product.
- `flag_ov`  out  1  registered; 1 when `of_q != 0`.
- `flag_z`  out  1  registered; 1 when the full 2N-bit product is zero.
- `valid`  out  1  1 while `res_q`, `of_q` and the flags hold the result for the current `x`,`y`.
- `state`  out  2  current FSM state: WAIT_A=00, WAIT_B=01, CALC=10, SHOW=11.

## Operation
- **Reset (`rst_n`=0, asynchronous):**
  - `x`, `y`, `res_q`, `of_q`, `flag_ov`, `flag_z`, `valid` = 0.
  - `state` = WAIT_A.
  - Synchronizer and edge-detect flops = 0.
- **Input conditioning:** `btn_load` and `btn_clr` each pass through a 2-flop synchronizer, then a rising-edge detector (third flop).
  - `ld_p` and `clr_p` are single-cycle pulses, one per press.
  - Holding a button produces no further pulses.
- **FSM:**
  - WAIT_A: on `ld_p`, `x` <= `sw`, go to WAIT_B.
  - WAIT_B: on `ld_p`, `y` <= `sw`, go to CALC.
  - CALC: unconditional, one cycle. At its closing edge, `res_q` <= `R`, `of_q` <= `Of`, `flag_ov` <= `|Of`, `flag_z` <= (`R`==0 && `Of`==0), `valid` <= 1. Go to SHOW.
  - SHOW: results are held. On `ld_p`: `x` <= `sw`, `valid` <= 0, go to WAIT_B; `res_q`, `of_q` and the flags keep their old values until the next CALC.
- **Clear:** `clr_p` in any state zeroes `x`, `y`, `res_q`, `of_q`, both flags and `valid`, and goes to WAIT_A.
- **Clear vs load:** if `clr_p` and `ld_p` occur in the same cycle, clear wins and the load is discarded.
- **Clear during CALC:** `clr_p` in CALC takes precedence over the result capture; nothing is latched.
- **Switch sampling:** `sw` is sampled only on the edge that consumes `ld_p`; it is don't-care otherwise.
- **Widths:** no arithmetic is performed here.
  - Full product = {`of_q`,`res_q`}, unsigned, range 0..(2^N-1)^2.
  - `flag_ov` means the product does not fit in N bits.

## Timing
- **Button to capture:** `btn_load` stable high before edge k.
  - Sync flop 1 at k, sync flop 2 at k+1.
  - `ld_p` is high during cycle k+1..k+2.
  - Operand captured at edge k+2; three edges after the press.
- **Operand B to valid:** `y` updates at edge t, which starts CALC.
  - The multiplier settles combinationally within the CALC cycle.
  - `res_q`/`of_q`/flags update and `valid`=1 at edge t+1.
- **Clear:** `btn_clr` high before edge k; all outputs are zero and `state`=WAIT_A after edge k+2.
- **Reset:** asynchronous assertion takes effect immediately, without a clock. Deassertion is synchronized externally and is not handled here.
- **Minimum load spacing:** none beyond the synchronizer; back-to-back presses separated by at least one low sample are each honoured.

## Test plan
- Reset, then load A=3, load B=5 -> `x`=0011, `y`=0101; one cycle after `y` loads: `res_q`=1111, `of_q`=0000, `flag_ov`=0, `flag_z`=0, `valid`=1, `state`=11.
- From SHOW, load A=7, then B=9 -> `valid` drops to 0 on the A load; after CALC: `res_q`=1111, `of_q`=0011, `flag_ov`=1, `flag_z`=0.
- Load A=0, B=13 -> `res_q`=0000, `of_q`=0000, `flag_z`=1, `flag_ov`=0; A=15, B=15 -> `res_q`=0001, `of_q`=1110, `flag_ov`=1.
- Hold `btn_load` high for 20 cycles in WAIT_A with `sw`=6 -> exactly one capture (`x`=0110), `state` stays WAIT_B.
- In WAIT_B, assert `btn_load` and `btn_clr` on the same edge -> `state`=WAIT_A, all outputs 0, `y` unchanged at 0.
- Pulse `rst_n` low mid-cycle while in CALC -> all outputs 0 immediately, no result captured, `state`=WAIT_A.
